// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-controller initiator path:
// controller bus widths, buffer capacity limit and the requester state encoding.
package mem_bus_pkg;

    localparam int MEM_ADDR_W      = 16;
    localparam int MEM_DATA_W      = 106;
    localparam int MEM_CNT_W       = 4;
    localparam int MAX_BYTES_LIMIT = 13;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        ABORT     = 3'd4
    } state_t;

endpackage

// File: rtl/mem_byte_gatherer.sv
// Write assembly buffer: collects bytes one at a time, tracks how many are held,
// flags pushes that arrive when full and packs the bytes onto the 106-bit write bus.
// Slots beyond the current count always hold zero, so the packed bus needs no masking.
module mem_byte_gatherer
    import mem_bus_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [7:0]            byte_i,
    input  logic                  clear_i,
    output logic [MEM_CNT_W-1:0]  count_o,
    output logic [MEM_CNT_W-1:0]  countNext_o,
    output logic                  dropped_o,
    output logic [MEM_DATA_W-1:0] data_o
);

    logic [7:0]           bytes_q [MAX_BYTES];
    logic [MEM_CNT_W-1:0] count_q;
    logic [MEM_CNT_W-1:0] count_d;
    logic                 full;
    logic                 accept;

    assign full      = (count_q == MEM_CNT_W'(MAX_BYTES));
    assign accept    = push_i && !full;
    assign dropped_o = push_i && full;

    // Next byte count: clearing wins, otherwise an accepted push bumps the count.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (accept) begin
            count_d = count_q + MEM_CNT_W'(1);
        end
    end

    // Store each accepted byte at the slot named by the current count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < MAX_BYTES; i++) begin
                bytes_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < MAX_BYTES; i++) begin
                if (clear_i) begin
                    bytes_q[i] <= '0;
                end else if (accept && (count_q == MEM_CNT_W'(i))) begin
                    bytes_q[i] <= byte_i;
                end
            end
        end
    end

    // Byte i lands at bits [8i+7:8i]; the top two bus bits stay zero.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            data_o[8*i +: 8] = bytes_q[i];
        end
    end

    assign count_o     = count_q;
    assign countNext_o = count_d;

endmodule

// File: rtl/mem_requester.sv
// Initiator front end for the memory controller. Accepts serial write bytes plus
// write-commit / single-byte-read commands, runs the CE/busy handshake with the
// controller, returns read data or completion pulses and aborts stalled transfers.
module mem_requester
    import mem_bus_pkg::*;
#(
    parameter int MAX_BYTES      = MAX_BYTES_LIMIT,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wrByteValid,
    input  logic [7:0]            wrByte,
    input  logic                  wrCommit,
    input  logic                  rdReq,
    input  logic [MEM_ADDR_W-1:0] reqAdress,
    output logic                  reqReady,
    output logic [MEM_CNT_W-1:0]  bytesQueued,
    output logic [7:0]            rdData,
    output logic                  rdDataValid,
    output logic                  wrDone,
    output logic                  error,
    output logic                  memCE,
    output logic                  memWrite,
    output logic [MEM_ADDR_W-1:0] memAdress,
    output logic [MEM_CNT_W-1:0]  memNumBytes,
    output logic [MEM_DATA_W-1:0] memDataToWrite,
    input  logic [7:0]            memDataRead,
    input  logic                  memBusy
);

    state_t                state_q;
    logic [TO_W-1:0]       wdog_q;
    logic                  reqReady_q;
    logic [7:0]            rdData_q;
    logic                  rdDataValid_q;
    logic                  wrDone_q;
    logic                  error_q;
    logic                  memCE_q;
    logic                  memWrite_q;
    logic [MEM_ADDR_W-1:0] memAdress_q;
    logic [MEM_CNT_W-1:0]  memNumBytes_q;

    logic                  pushEn;
    logic                  bufClear;
    logic                  pushDropped;
    logic                  wdogExpired;
    logic [MEM_CNT_W-1:0]  countNext;

    // Bytes are only gathered while idle; the buffer empties when a write
    // finishes or a transfer is abandoned.
    assign pushEn      = wrByteValid && (state_q == IDLE);
    assign bufClear    = ((state_q == WAIT_DONE) && !memBusy && memWrite_q) || (state_q == ABORT);
    assign wdogExpired = (wdog_q == TO_W'(TIMEOUT_CYCLES));

    mem_byte_gatherer #(
        .MAX_BYTES (MAX_BYTES)
    ) u_gatherer (
        .clk         (clk),
        .reset       (reset),
        .push_i      (pushEn),
        .byte_i      (wrByte),
        .clear_i     (bufClear),
        .count_o     (bytesQueued),
        .countNext_o (countNext),
        .dropped_o   (pushDropped),
        .data_o      (memDataToWrite)
    );

    // Transaction sequencer with registered outputs. reqReady returns one cycle
    // after completion/abort so the completion pulse and the next accept never overlap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wdog_q        <= '0;
            reqReady_q    <= 1'b1;
            rdData_q      <= '0;
            rdDataValid_q <= 1'b0;
            wrDone_q      <= 1'b0;
            error_q       <= 1'b0;
            memCE_q       <= 1'b0;
            memWrite_q    <= 1'b0;
            memAdress_q   <= '0;
            memNumBytes_q <= '0;
        end else begin
            rdDataValid_q <= 1'b0;
            wrDone_q      <= 1'b0;
            memCE_q       <= 1'b0;
            if (pushDropped) begin
                error_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    wdog_q <= '0;
                    if (!reqReady_q) begin
                        reqReady_q <= 1'b1;
                    end else if (wrCommit && rdReq) begin
                        error_q <= 1'b1;
                    end else if (wrCommit) begin
                        if (countNext == '0) begin
                            error_q <= 1'b1;
                        end else begin
                            error_q       <= pushDropped;
                            reqReady_q    <= 1'b0;
                            memWrite_q    <= 1'b1;
                            memAdress_q   <= reqAdress;
                            memNumBytes_q <= countNext;
                            state_q       <= ISSUE;
                        end
                    end else if (rdReq) begin
                        error_q       <= pushDropped;
                        reqReady_q    <= 1'b0;
                        memWrite_q    <= 1'b0;
                        memAdress_q   <= reqAdress;
                        memNumBytes_q <= MEM_CNT_W'(1);
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog_q <= '0;
                    if (!memBusy) begin
                        memCE_q <= 1'b1;
                        state_q <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (memBusy) begin
                        wdog_q  <= '0;
                        state_q <= WAIT_DONE;
                    end else if (wdogExpired) begin
                        wdog_q  <= '0;
                        state_q <= ABORT;
                    end else begin
                        wdog_q <= wdog_q + TO_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!memBusy) begin
                        if (memWrite_q) begin
                            wrDone_q <= 1'b1;
                        end else begin
                            rdData_q      <= memDataRead;
                            rdDataValid_q <= 1'b1;
                        end
                        wdog_q  <= '0;
                        state_q <= IDLE;
                    end else if (wdogExpired) begin
                        wdog_q  <= '0;
                        state_q <= ABORT;
                    end else begin
                        wdog_q <= wdog_q + TO_W'(1);
                    end
                end
                ABORT: begin
                    error_q       <= 1'b1;
                    memWrite_q    <= 1'b0;
                    memNumBytes_q <= '0;
                    wdog_q        <= '0;
                    state_q       <= IDLE;
                end
                default: begin
                    wdog_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign reqReady    = reqReady_q;
    assign rdData      = rdData_q;
    assign rdDataValid = rdDataValid_q;
    assign wrDone      = wrDone_q;
    assign error       = error_q;
    assign memCE       = memCE_q;
    assign memWrite    = memWrite_q;
    assign memAdress   = memAdress_q;
    assign memNumBytes = memNumBytes_q;

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: a small controller model answers CE strobes, a monitor
// compares every strobe and every completion pulse against queued expectations.
module tb_mem_requester;

    localparam int TIMEOUT_CYCLES = 255;

    typedef struct {
        logic         isWrite;
        logic [15:0]  addr;
        logic [3:0]   numBytes;
        logic [105:0] data;
        logic         checkData;
    } issue_t;

    typedef struct {
        logic        isRead;
        logic [15:0] addr;
        logic [7:0]  data;
    } compl_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         wrByteValid = 1'b0;
    logic [7:0]   wrByte = '0;
    logic         wrCommit = 1'b0;
    logic         rdReq = 1'b0;
    logic [15:0]  reqAdress = '0;
    logic         reqReady;
    logic [3:0]   bytesQueued;
    logic [7:0]   rdData;
    logic         rdDataValid;
    logic         wrDone;
    logic         error;
    logic         memCE;
    logic         memWrite;
    logic [15:0]  memAdress;
    logic [3:0]   memNumBytes;
    logic [105:0] memDataToWrite;
    logic [7:0]   memDataRead;
    logic         memBusy;

    // Controller model knobs
    logic         modelBusy;
    logic         forceBusy = 1'b0;
    logic         neverRespond = 1'b0;
    logic [7:0]   modelData = '0;
    int           busyDelay = 2;
    int           busyLen = 4;
    int           modelPhase;
    int           modelCnt;

    int           checkCount = 0;
    int           errorCount = 0;
    int           ceCount = 0;
    int           rdValidCount = 0;
    int           wrDoneCount = 0;

    issue_t       expIssue[$];
    compl_t       expCompl[$];
    logic [7:0]   tbBuf[$];

    assign memBusy = modelBusy | forceBusy;

    mem_requester dut (
        .clk            (clk),
        .reset          (reset),
        .wrByteValid    (wrByteValid),
        .wrByte         (wrByte),
        .wrCommit       (wrCommit),
        .rdReq          (rdReq),
        .reqAdress      (reqAdress),
        .reqReady       (reqReady),
        .bytesQueued    (bytesQueued),
        .rdData         (rdData),
        .rdDataValid    (rdDataValid),
        .wrDone         (wrDone),
        .error          (error),
        .memCE          (memCE),
        .memWrite       (memWrite),
        .memAdress      (memAdress),
        .memNumBytes    (memNumBytes),
        .memDataToWrite (memDataToWrite),
        .memDataRead    (memDataRead),
        .memBusy        (memBusy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Controller model: after a CE strobe, raise busy busyDelay cycles later,
    // hold it busyLen cycles, then drop it with the read data valid.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            modelBusy   <= 1'b0;
            modelPhase  <= 0;
            modelCnt    <= 0;
            memDataRead <= '0;
        end else begin
            case (modelPhase)
                0: if (memCE && !neverRespond) begin
                    modelPhase <= 1;
                    modelCnt   <= busyDelay;
                end
                1: if (modelCnt <= 1) begin
                    modelBusy  <= 1'b1;
                    modelCnt   <= busyLen;
                    modelPhase <= 2;
                end else begin
                    modelCnt <= modelCnt - 1;
                end
                default: if (modelCnt <= 1) begin
                    modelBusy   <= 1'b0;
                    memDataRead <= modelData;
                    modelPhase  <= 0;
                end else begin
                    modelCnt <= modelCnt - 1;
                end
            endcase
        end
    end

    // Monitor: every CE strobe and completion pulse is matched against the queues.
    always @(negedge clk) begin
        if (memCE) begin
            ceCount++;
            checkOutput("ceWhileBusy", memBusy, 0);
            if (expIssue.size() == 0) begin
                checkOutput("spuriousCE", memCE, 0);
            end else begin
                issue_t e;
                e = expIssue.pop_front();
                checkOutput("issueWrite", memWrite, e.isWrite);
                checkOutput("issueAddr", memAdress, e.addr);
                checkOutput("issueNumBytes", memNumBytes, e.numBytes);
                if (e.checkData) checkOutput("issueData", memDataToWrite, e.data);
            end
        end
        if (rdDataValid) rdValidCount++;
        if (wrDone) wrDoneCount++;
        if (rdDataValid || wrDone) begin
            if (expCompl.size() == 0) begin
                checkOutput("spuriousCompletion", {rdDataValid, wrDone}, 0);
            end else begin
                compl_t c;
                c = expCompl.pop_front();
                checkOutput("complKind", {rdDataValid, wrDone}, c.isRead ? 2'b10 : 2'b01);
                checkOutput("complAddrHeld", memAdress, c.addr);
                if (c.isRead) checkOutput("rdData", rdData, c.data);
            end
        end
    end

    task automatic pushByte(input logic [7:0] b);
        if (tbBuf.size() < 13) tbBuf.push_back(b);
        @(negedge clk);
        wrByteValid = 1'b1;
        wrByte      = b;
        @(negedge clk);
        wrByteValid = 1'b0;
    endtask

    task automatic commitWrite(input logic [15:0] addr, input bit expectDone);
        if (tbBuf.size() > 0) begin
            issue_t e;
            compl_t c;
            e.isWrite   = 1'b1;
            e.addr      = addr;
            e.numBytes  = 4'(tbBuf.size());
            e.data      = '0;
            for (int i = 0; i < tbBuf.size(); i++) e.data[8*i +: 8] = tbBuf[i];
            e.checkData = 1'b1;
            expIssue.push_back(e);
            c.isRead = 1'b0;
            c.addr   = addr;
            c.data   = '0;
            if (expectDone) expCompl.push_back(c);
            tbBuf.delete();
        end
        @(negedge clk);
        wrCommit  = 1'b1;
        reqAdress = addr;
        @(negedge clk);
        wrCommit  = 1'b0;
    endtask

    task automatic readReq(input logic [15:0] addr, input logic [7:0] data, input bit expectDone);
        issue_t e;
        compl_t c;
        e.isWrite   = 1'b0;
        e.addr      = addr;
        e.numBytes  = 4'd1;
        e.data      = '0;
        e.checkData = 1'b0;
        expIssue.push_back(e);
        c.isRead = 1'b1;
        c.addr   = addr;
        c.data   = data;
        if (expectDone) expCompl.push_back(c);
        modelData = data;
        @(negedge clk);
        rdReq     = 1'b1;
        reqAdress = addr;
        @(negedge clk);
        rdReq     = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (reqReady !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (reqReady !== 1'b1) checkOutput(tag, reqReady, 1);
    endtask

    task automatic applyStimulus();
        int ceBefore;
        int pulses;
        int n;
        logic [127:0] fullData;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rstReqReady", reqReady, 1);
        checkOutput("rstBytesQueued", bytesQueued, 0);
        checkOutput("rstFlags", {memCE, memWrite, error, rdDataValid, wrDone}, 0);
        checkOutput("rstBus", {memAdress, memNumBytes, rdData}, 0);
        checkOutput("rstData", memDataToWrite, 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: three-byte write
        $display("[TB] test 1: three byte write");
        busyDelay = 2;
        busyLen   = 4;
        pushByte(8'h11);
        pushByte(8'h22);
        pushByte(8'h33);
        checkOutput("t1Queued", bytesQueued, 3);
        ceBefore = ceCount;
        pulses   = wrDoneCount;
        commitWrite(16'hC000, 1);
        checkOutput("t1ReadyDrop", reqReady, 0);
        waitIdle("t1Idle", 100);
        checkOutput("t1OneCE", ceCount - ceBefore, 1);
        checkOutput("t1OneWrDone", wrDoneCount - pulses, 1);
        checkOutput("t1QueuedClr", bytesQueued, 0);
        checkOutput("t1DataClr", memDataToWrite, 0);

        // 2: read
        $display("[TB] test 2: read");
        pulses = rdValidCount;
        readReq(16'hD020, 8'h5A, 1);
        checkOutput("t2CeNotYet", memCE, 0);
        @(negedge clk);
        checkOutput("t2CeLatency", memCE, 1);
        waitIdle("t2Idle", 100);
        checkOutput("t2OneValid", rdValidCount - pulses, 1);
        repeat (4) @(negedge clk);
        checkOutput("t2RdHold", rdData, 8'h5A);

        // 3: controller busy at command time
        $display("[TB] test 3: busy at issue");
        forceBusy = 1'b1;
        ceBefore  = ceCount;
        readReq(16'h1234, 8'hA5, 1);
        repeat (8) @(negedge clk);
        checkOutput("t3NoCEWhileBusy", ceCount - ceBefore, 0);
        checkOutput("t3Accepted", reqReady, 0);
        forceBusy = 1'b0;
        waitIdle("t3Idle", 100);
        checkOutput("t3OneCE", ceCount - ceBefore, 1);
        checkOutput("t3RdData", rdData, 8'hA5);

        // 4: controller never answers
        $display("[TB] test 4: watchdog");
        neverRespond = 1'b1;
        readReq(16'h4000, 8'h00, 0);
        n = 0;
        while (error !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t4AbortLatency", (n >= TIMEOUT_CYCLES && n <= TIMEOUT_CYCLES + 8), 1);
        waitIdle("t4Idle", 10);
        checkOutput("t4ErrorSticky", error, 1);
        checkOutput("t4NumBytesClr", memNumBytes, 0);
        neverRespond = 1'b0;
        readReq(16'h4001, 8'h3C, 1);
        checkOutput("t4ErrorCleared", error, 0);
        waitIdle("t4Idle2", 100);
        checkOutput("t4RdData", rdData, 8'h3C);

        // 5: error cases and the full buffer boundary
        $display("[TB] test 5: errors and full buffer");
        ceBefore = ceCount;
        commitWrite(16'h0BAD, 1);
        checkOutput("t5EmptyCommitErr", error, 1);
        checkOutput("t5EmptyReady", reqReady, 1);
        repeat (3) @(negedge clk);
        checkOutput("t5EmptyNoCE", ceCount - ceBefore, 0);
        readReq(16'h0001, 8'h01, 1);
        checkOutput("t5ReadClears", error, 0);
        waitIdle("t5Idle1", 100);
        for (int i = 0; i < 13; i++) pushByte(8'hA0 + 8'(i));
        checkOutput("t5Queued13", bytesQueued, 13);
        checkOutput("t5NoErrAt13", error, 0);
        pushByte(8'hFF);
        checkOutput("t5Saturate", bytesQueued, 13);
        checkOutput("t5OverflowErr", error, 1);
        readReq(16'h0002, 8'h77, 1);
        waitIdle("t5Idle2", 100);
        checkOutput("t5ErrClr2", error, 0);
        checkOutput("t5BufKeptOnRead", bytesQueued, 13);
        ceBefore = ceCount;
        @(negedge clk);
        wrCommit  = 1'b1;
        rdReq     = 1'b1;
        reqAdress = 16'h5555;
        @(negedge clk);
        wrCommit  = 1'b0;
        rdReq     = 1'b0;
        checkOutput("t5BothErr", error, 1);
        checkOutput("t5BothReady", reqReady, 1);
        repeat (3) @(negedge clk);
        checkOutput("t5BothNoCE", ceCount - ceBefore, 0);
        checkOutput("t5BothBufKept", bytesQueued, 13);
        fullData = '0;
        for (int i = 0; i < 13; i++) fullData[8*i +: 8] = 8'hA0 + 8'(i);
        checkOutput("t5FullPacked", memDataToWrite, fullData);
        commitWrite(16'hBEEF, 1);
        waitIdle("t5Idle3", 100);
        checkOutput("t5QueuedClr", bytesQueued, 0);

        // 6: reset in the middle of WAIT_DONE
        $display("[TB] test 6: reset mid transfer");
        busyDelay = 1;
        busyLen   = 20;
        pushByte(8'h01);
        pushByte(8'h02);
        commitWrite(16'hE000, 0);
        n = 0;
        while (memBusy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6BusySeen", memBusy, 1);
        repeat (2) @(negedge clk);
        checkOutput("t6QueuedBefore", bytesQueued, 2);
        pulses = rdValidCount + wrDoneCount;
        reset = 1'b0;
        #1;
        checkOutput("t6AsyncCE", memCE, 0);
        checkOutput("t6AsyncReady", reqReady, 1);
        checkOutput("t6AsyncQueued", bytesQueued, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("t6NoCompletion", rdValidCount + wrDoneCount - pulses, 0);
        checkOutput("t6Ready", reqReady, 1);
    endtask

    task automatic checkOutputs();
        checkOutput("issueQueueDrained", expIssue.size(), 0);
        checkOutput("complQueueDrained", expCompl.size(), 0);
    endtask

    initial begin
        applyStimulus();
        checkOutputs();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Global time bound so the bench always ends on its own.
    initial begin
        #200000;
        errorCount++;
        $display("[TB] FAIL globalTimeout: got time %0t, expected end before it", $time);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $fatal(1, "[TB] time limit reached");
    end

endmodule
